// File: rtl/tnn_cls_scheduler.sv
// rtl/tnn_cls_scheduler.sv - round-robin sharing of one combinational TNN classifier
// Winning features are held for SETTLE_CYC cycles so the classifier can be a multicycle path.
module tnn_cls_scheduler #(
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*12-1:0]   req_data,
  output logic [11:0]           cls_features,
  input  logic                  cls_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_class,
  input  logic                  stat_clear,
  output logic [CNT_W-1:0]      stat_total,
  output logic [CNT_W-1:0]      stat_pos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [11:0]       feat_q, feat_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic              rcls_q, rcls_d;
  logic              rvalid_q, rvalid_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic [CNT_W-1:0]  pos_q, pos_d;

  logic              hi_any, lo_any, gnt_any;
  logic [ID_W-1:0]   hi_idx, lo_idx, gnt_idx;
  logic [11:0]       gnt_data;
  logic              handshake;

  // Circular search from last_q+1: prefer the lowest valid index above last_q, else wrap to the lowest overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_W'(i);
        if (ID_W'(i) > last_q) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        gnt_data = req_data[i*12 +: 12];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_any) begin
      req_ready = N_REQ'(1) << gnt_idx;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    feat_d    = feat_q;
    rid_d     = rid_q;
    rcls_d    = rcls_q;
    rvalid_d  = rvalid_q;
    tot_d     = tot_q;
    pos_d     = pos_q;
    handshake = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          feat_d  = gnt_data;
          rid_d   = gnt_idx;
          last_d  = gnt_idx;
          cnt_d   = 4'(SETTLE_CYC - 1);
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q == 4'd0) begin
          rcls_d   = cls_result;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rvalid_d  = 1'b0;
          handshake = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear has priority so a coincident handshake is dropped from the statistics.
    if (stat_clear) begin
      tot_d = '0;
      pos_d = '0;
    end else if (handshake) begin
      if (tot_q != {CNT_W{1'b1}}) begin
        tot_d = tot_q + CNT_W'(1);
      end
      if (rcls_q && (pos_q != {CNT_W{1'b1}})) begin
        pos_d = pos_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= ID_W'(N_REQ - 1);
      feat_q   <= '0;
      rid_q    <= '0;
      rcls_q   <= 1'b0;
      rvalid_q <= 1'b0;
      tot_q    <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      feat_q   <= feat_d;
      rid_q    <= rid_d;
      rcls_q   <= rcls_d;
      rvalid_q <= rvalid_d;
      tot_q    <= tot_d;
      pos_q    <= pos_d;
    end
  end

  assign cls_features = feat_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_id       = rid_q;
  assign rsp_class    = rcls_q;
  assign stat_total   = tot_q;
  assign stat_pos     = pos_q;

endmodule

// File: tb/tb_tnn_cls_scheduler.sv
// tb/tb_tnn_cls_scheduler.sv - randomized bench for tnn_cls_scheduler against a timing-level reference model
module tb_tnn_cls_scheduler;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int S   = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*12-1:0] req_data = '0;
  logic [11:0]     cls_features;
  logic            cls_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_class;
  logic            stat_clear = 1'b0;
  logic [CW-1:0]   stat_total;
  logic [CW-1:0]   stat_pos;

  int   cls_mode = 1;
  logic tog = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   saw_grant;

  bit          m_busy;
  int          m_acc;
  int          m_rid;
  int          m_last;
  logic [11:0] m_feat;
  logic        m_rcls;
  int          m_tot;
  int          m_pos;
  int          obs_id[$];
  int          obs_cyc[$];

  tnn_cls_scheduler #(.N_REQ(N), .ID_W(IDW), .SETTLE_CYC(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .cls_features(cls_features), .cls_result(cls_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_class(rsp_class),
    .stat_clear(stat_clear), .stat_total(stat_total), .stat_pos(stat_pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;

  // Stand-in classifier: positive when the a..c ternary mass outweighs d..f.
  function automatic logic tnn(input logic [11:0] x);
    int p, q;
    p = int'(x[1:0]) + int'(x[3:2]) + int'(x[5:4]);
    q = int'(x[7:6]) + int'(x[9:8]) + int'(x[11:10]);
    return p > q;
  endfunction

  assign cls_result = (cls_mode == 0) ? tnn(cls_features) : ((cls_mode == 1) ? 1'b1 : tog);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_acc = 0; m_rid = 0; m_last = N - 1;
    m_feat = '0; m_rcls = 1'b0; m_tot = 0; m_pos = 0;
  endtask

  task automatic model_step();
    logic         exp_rv;
    logic [N-1:0] exp_rdy;
    int           g;
    bit           hs;
    exp_rv  = m_busy && (cyc >= m_acc + S);
    g       = (rst_n && !m_busy) ? rr_pick(req_valid, m_last) : -1;
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_id", rsp_id, m_rid);
    check("rsp_class", rsp_class, m_rcls);
    check("cls_features", cls_features, m_feat);
    check("stat_total", stat_total, m_tot);
    check("stat_pos", stat_pos, m_pos);
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_busy && (cyc == m_acc + S - 1)) begin
      m_rcls = (cls_mode == 0) ? tnn(m_feat) : ((cls_mode == 1) ? 1'b1 : tog);
    end
    hs = exp_rv && rsp_ready;
    if (stat_clear) begin
      m_tot = 0;
      m_pos = 0;
    end else if (hs) begin
      if (m_tot < SAT) m_tot++;
      if (m_rcls && m_pos < SAT) m_pos++;
    end
    if (hs) m_busy = 1'b0;
    if (g >= 0) begin
      m_busy = 1'b1; m_acc = cyc + 1; m_rid = g; m_last = g;
      m_feat = req_data[g*12 +: 12];
    end
  endtask

  task automatic step();
    @(negedge clk);
    saw_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        saw_grant = 1'b1;
        obs_id.push_back(i);
        obs_cyc.push_back(cyc);
      end
    end
    model_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_sample(input int id, input logic [11:0] data, input int hold);
    int n;
    req_data[id*12 +: 12] = data;
    req_valid = N'(1) << id;
    n = 0;
    do begin step(); n++; end while (!saw_grant && n < 20);
    if (!saw_grant) check("grant_timeout", 1, 0);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    if (!rsp_valid) check("rsp_timeout", 1, 0);
    repeat (hold) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_features", cls_features, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_class", rsp_class, 0);
    check("rst_stats", {stat_total, stat_pos}, 0);
    rst_n = 1'b1;

    // Single sample from requester 1
    cls_mode = 1;
    req_data[12 +: 12] = 12'hA5C;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    step();
    check("single_grant", obs_id.size() > 0 ? obs_id[obs_id.size()-1] : -1, 1);
    req_valid = '0;
    check("single_ready_drop", req_ready, 0);
    step();
    check("single_not_yet", rsp_valid, 0);
    step();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 1);
    check("single_rsp_class", rsp_class, 1);
    check("single_features", cls_features, 12'hA5C);
    step();
    check("single_total", stat_total, 1);
    check("single_pos", stat_pos, 1);

    // Round-robin with everyone valid
    rst_n = 1'b0; step(); rst_n = 1'b1;
    obs_id.delete(); obs_cyc.delete();
    cls_mode = 0;
    for (int i = 0; i < N; i++) req_data[i*12 +: 12] = 12'($urandom);
    req_valid = '1;
    rsp_ready = 1'b1;
    n = 0;
    while (obs_id.size() < 6 && n < 80) begin step(); n++; end
    check("rr_count", obs_id.size(), 6);
    for (int k = 0; k < 6 && k < obs_id.size(); k++) begin
      check("rr_order", obs_id[k], exp_order[k]);
      if (k > 0) check("rr_spacing", obs_cyc[k] - obs_cyc[k-1], S + 2);
    end
    req_valid = '0;
    repeat (S + 3) step();

    // Backpressure: other requesters valid, response held for 10 cycles
    rsp_ready = 1'b0;
    req_data[36 +: 12] = 12'h03F;
    req_valid = 4'b1000;
    n = 0;
    do begin step(); n++; end while (!saw_grant && n < 20);
    req_valid = 4'b0111;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    repeat (10) step();
    check("bp_valid_held", rsp_valid, 1);
    check("bp_id_held", rsp_id, 3);
    check("bp_class_held", rsp_class, tnn(12'h03F));
    check("bp_ready_low", req_ready, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Settle timing against a toggling classifier
    cls_mode = 2;
    for (int k = 0; k < 6; k++) run_sample($urandom_range(0, N-1), 12'($urandom), k % 3);

    // Stats saturation and clear coinciding with a handshake
    cls_mode = 1;
    for (int k = 0; k < 17; k++) run_sample(k % N, 12'($urandom), 0);
    check("sat_total", stat_total, SAT);
    check("sat_pos", stat_pos, SAT);
    req_valid = 4'b0001;
    n = 0;
    do begin step(); n++; end while (!saw_grant && n < 20);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    stat_clear = 1'b1;
    rsp_ready = 1'b1;
    step();
    stat_clear = 1'b0;
    rsp_ready = 1'b0;
    check("clr_total", stat_total, 0);
    check("clr_pos", stat_pos, 0);
    check("clr_rsp_done", rsp_valid, 0);

    // Reset in the middle of EVAL
    req_data[24 +: 12] = 12'h7E1;
    req_valid = 4'b0100;
    n = 0;
    do begin step(); n++; end while (!saw_grant && n < 20);
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_features", cls_features, 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_class", rsp_class, 0);
    check("mid_rst_stats", {stat_total, stat_pos}, 0);
    req_valid = '1;
    step();
    check("mid_rst_grant0", obs_id.size() > 0 ? obs_id[obs_id.size()-1] : -1, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (S + 3) step();

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          req_data[i*12 +: 12] = 12'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready  = ($urandom_range(0, 9) < 6);
      stat_clear = ($urandom_range(0, 49) == 0);
      cls_mode   = $urandom_range(0, 2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
